// File: rtl/png_jkff_bank.sv
// png_jkff_bank: N-channel JK/D/T flip-flop bank for the Pong TTL netlist.
// Every channel runs on the system clock. A falling edge of the per-channel
// logic clock becomes a one-cycle update enable.
// Optional build macro PNG_JKFF_BANK_FILTER_EN adds a per-channel lclk
// synchroniser and glitch filter.
module png_jkff_bank #(
    parameter int unsigned    N           = 4,
    parameter int unsigned    MODE        = 0,
    parameter logic [N-1:0]   INIT        = '0,
    parameter int unsigned    FILT_CYCLES = 2
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [N-1:0] lclk,
    input  logic [N-1:0] j,
    input  logic [N-1:0] k,
    input  logic [N-1:0] _set,
    input  logic [N-1:0] _clr,
    output logic [N-1:0] q,
    output logic [N-1:0] _q,
    output logic [N-1:0] fall
);

    // Reject out-of-range configurations at elaboration
    if (N < 1 || N > 32 || FILT_CYCLES < 1 || FILT_CYCLES > 15) begin : g_param_err
        $error("png_jkff_bank: parameter out of range");
    end

    logic [N-1:0] lvl;
    logic [N-1:0] fedge;
    logic [N-1:0] q_d, q_q;
    logic [N-1:0] lprev_d, lprev_q;
    logic [N-1:0] fall_d, fall_q;

`ifdef PNG_JKFF_BANK_FILTER_EN
    localparam logic [3:0] FiltLast = 4'(FILT_CYCLES - 1);

    logic [N-1:0]      sync1_q, sync2_q;
    logic [N-1:0]      flt_d, flt_q;
    logic [N-1:0][3:0] cnt_d, cnt_q;

    // Filter: flip the level after FILT_CYCLES consecutive disagreeing samples
    always_comb begin
        flt_d = flt_q;
        cnt_d = cnt_q;
        for (int i = 0; i < N; i++) begin
            if (sync2_q[i] != flt_q[i]) begin
                if (cnt_q[i] >= FiltLast) begin
                    flt_d[i] = sync2_q[i];
                    cnt_d[i] = 4'd0;
                end else if (cnt_q[i] != 4'hf) begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end else begin
                cnt_d[i] = 4'd0;
            end
        end
    end

    // Synchroniser, counter and filtered-level registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1_q <= '0;
            sync2_q <= '0;
            flt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= lclk;
            sync2_q <= sync1_q;
            flt_q   <= flt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign lvl = flt_q;
`else
    assign lvl = lclk;
`endif

    // Next state: clear beats set beats edge update; an edge under set/clear is consumed
    always_comb begin
        q_d     = q_q;
        fall_d  = '0;
        lprev_d = lvl;
        fedge   = lprev_q & ~lvl;
        for (int i = 0; i < N; i++) begin
            if (!_clr[i]) begin
                q_d[i] = 1'b0;
            end else if (!_set[i]) begin
                q_d[i] = 1'b1;
            end else if (fedge[i]) begin
                fall_d[i] = 1'b1;
                case (MODE)
                    1: q_d[i] = j[i];
                    2: q_d[i] = q_q[i] ^ j[i];
                    default: begin
                        case ({j[i], k[i]})
                            2'b00:   q_d[i] = q_q[i];
                            2'b01:   q_d[i] = 1'b0;
                            2'b10:   q_d[i] = 1'b1;
                            default: q_d[i] = ~q_q[i];
                        endcase
                    end
                endcase
            end
        end
    end

    // State, previous-level and strobe registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_q     <= INIT;
            lprev_q <= '0;
            fall_q  <= '0;
        end else begin
            q_q     <= q_d;
            lprev_q <= lprev_d;
            fall_q  <= fall_d;
        end
    end

    assign q    = q_q;
    assign _q   = ~q_q;
    assign fall = fall_q;

endmodule
